// File: rtl/ac_sweep_sequencer.sv
// Purpose  : steps a DDS sine source through N frequency points (settle, dwell, one measurement handshake per point).
// Latency  : start -> src_en one cycle; each point spends settle_cyc+1 cycles in SETTLE, dwell_cyc+1 in DWELL, then MEAS.
// Backpress: meas_req is held until meas_ack is sampled high; the sweep stalls in MEAS indefinitely while ack is absent.
//
// Optional build macro: AC_SWEEP_PHASE_RESET_EN
//   defined     -> phase accumulator is cleared on entry to SETTLE of every point (coherent per-point start phase)
//   not defined -> phase runs continuously across point changes (no waveform discontinuity)
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   start, abort             start pulse (honoured only in IDLE), abort level (highest priority)
//   f_start, f_step          tuning word of point 0, per-point tuning increment (modulo 2**PHASE_W)
//   n_points                 number of points (0 completes at once)
//   settle_cyc, dwell_cyc    per-point settle and dwell counts
//   amp_cfg                  amplitude code used while the source is enabled
//   src_en, amp_out          source enable, amplitude code to the source
//   phase_out, point_idx     phase accumulator, current point index
//   meas_req, meas_ack       measurement handshake
//   busy, done               not-IDLE flag, one-cycle completion pulse
module ac_sweep_sequencer #(
  parameter int PHASE_W = 24,
  parameter int AMP_W   = 12,
  parameter int NPTS_W  = 8,
  parameter int TIME_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [PHASE_W-1:0] f_start,
  input  logic [PHASE_W-1:0] f_step,
  input  logic [NPTS_W-1:0]  n_points,
  input  logic [TIME_W-1:0]  settle_cyc,
  input  logic [TIME_W-1:0]  dwell_cyc,
  input  logic [AMP_W-1:0]   amp_cfg,
  output logic               src_en,
  output logic [AMP_W-1:0]   amp_out,
  output logic [PHASE_W-1:0] phase_out,
  output logic [NPTS_W-1:0]  point_idx,
  output logic               meas_req,
  input  logic               meas_ack,
  output logic               busy,
  output logic               done
);

`ifdef AC_SWEEP_PHASE_RESET_EN
  localparam bit PHASE_CLR = 1'b1;
`else
  localparam bit PHASE_CLR = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_DWELL  = 3'd2,
    S_MEAS   = 3'd3,
    S_NEXT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  // Configuration captured at start; host may change its registers mid-sweep.
  logic [PHASE_W-1:0] tuning;
  logic [PHASE_W-1:0] step_reg;
  logic [AMP_W-1:0]   amp_reg;
  logic [NPTS_W-1:0]  npts_reg;
  logic [TIME_W-1:0]  settle_reg;
  logic [TIME_W-1:0]  dwell_reg;

  logic [TIME_W-1:0]  cnt;
  logic [PHASE_W-1:0] phase;
  logic [NPTS_W-1:0]  idx;

  logic [NPTS_W-1:0]  last_idx;
  logic [TIME_W-1:0]  settle_src;
  logic               load_sweep;
  logic               enter_settle;
  logic               adv_point;

  assign last_idx = npts_reg - 1'b1;

  // SETTLE is entered from IDLE (registers not yet loaded) or from NEXT.
  assign settle_src   = (state == S_IDLE) ? settle_cyc : settle_reg;
  assign load_sweep   = (state == S_IDLE) && start && !abort;
  assign enter_settle = (state_nxt == S_SETTLE) && (state != S_SETTLE);
  assign adv_point    = (state == S_NEXT) && (state_nxt == S_SETTLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every transition including start.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (n_points == '0) ? S_DONE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt == '0) begin
          state_nxt = S_DWELL;
        end
      end
      S_DWELL: begin
        if (cnt == '0) begin
          state_nxt = S_MEAS;
        end
      end
      S_MEAS: begin
        if (meas_ack) begin
          state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        state_nxt = (idx == last_idx) ? S_DONE : S_SETTLE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
    end
  end

  // Outputs decode the registered state, so abort and reset take effect within a cycle.
  always_comb begin
    src_en   = 1'b0;
    meas_req = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      S_IDLE:   busy     = 1'b0;
      S_SETTLE: src_en   = 1'b1;
      S_DWELL:  src_en   = 1'b1;
      S_MEAS: begin
        src_en   = 1'b1;
        meas_req = 1'b1;
      end
      S_NEXT:   src_en   = 1'b1;
      S_DONE:   done     = 1'b1;
      default:  busy     = 1'b0;
    endcase
    amp_out = src_en ? amp_reg : '0;
  end

  assign phase_out = phase;
  assign point_idx = idx;

  // Datapath: configuration capture, point index, tuning word, interval counter, phase accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tuning     <= '0;
      step_reg   <= '0;
      amp_reg    <= '0;
      npts_reg   <= '0;
      settle_reg <= '0;
      dwell_reg  <= '0;
      idx        <= '0;
      cnt        <= '0;
      phase      <= '0;
    end else begin
      if (load_sweep) begin
        tuning     <= f_start;
        step_reg   <= f_step;
        amp_reg    <= amp_cfg;
        npts_reg   <= n_points;
        settle_reg <= settle_cyc;
        dwell_reg  <= dwell_cyc;
        idx        <= '0;
      end else if (adv_point) begin
        idx    <= idx + 1'b1;
        tuning <= tuning + step_reg;
      end

      // Counter is loaded on entry and exits the interval the cycle it reads zero.
      if (enter_settle) begin
        cnt <= settle_src;
      end else if ((state == S_SETTLE) && (state_nxt == S_DWELL)) begin
        cnt <= dwell_reg;
      end else if (((state == S_SETTLE) || (state == S_DWELL)) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      // The add uses the tuning word in force this cycle; a point change applies from the next cycle.
      if (PHASE_CLR && enter_settle) begin
        phase <= '0;
      end else if (src_en) begin
        phase <= phase + tuning;
      end
    end
  end

endmodule
